// File: rtl/shumezuesi_sekuencial_pkg.sv
// Shared constants and FSM encoding for the sequential shift-add multiplier.
// Used by the CPU control blocks.
package shumezuesi_sekuencial_pkg;

  localparam int WIDTH = 16;
  localparam int STEPS = 16;
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shumezuesi_sekuencial_mbledhesi.sv
// Team 16-bit ripple-carry adder.
// It is the only arithmetic element of the sequential multiplier.
module Mbledhesi16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [16:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < 16; g++) begin : g_fa
    assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
    assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_carry[16];

endmodule

// File: rtl/shumezuesi_sekuencial.sv
// Sequential 16x16 unsigned multiplier: one add-and-shift step per cycle for 16 cycles.
// Uses a single ripple adder. Product and overflow are held between completions.
module shumezuesi_sekuencial
  import shumezuesi_sekuencial_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_overflow;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic                 w_accept;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_shifted;

  assign w_addend  = r_acc_lo[0] ? r_mcand : '0;
  assign w_last    = (r_count == CNT_W'(STEPS - 1));
  // The adder carry-out becomes the new MSB, so 0xFFFF*0xFFFF keeps every bit.
  assign w_shifted = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};

  Mbledhesi16bit u_adder (
    .i_a   (r_acc_hi),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: the reset clears every datapath register, so an aborted run leaves product at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_mcand    <= '0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= b;
      r_mcand  <= a;
    end else if (r_state == S_RUN) begin
      {r_acc_hi, r_acc_lo} <= w_shifted;
      if (w_last) begin
        r_product  <= w_shifted;
        r_overflow <= |w_shifted[2*WIDTH-1:WIDTH];
      end else begin
        // The counter parks at the terminal value until the next acceptance.
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign product  = r_product;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_shumezuesi_sekuencial.sv
// Self-checking bench: cycle-level behavioural model plus directed and random multiplies.
module tb_shumezuesi_sekuencial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  shumezuesi_sekuencial dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request seen when not running starts a 16-cycle countdown.
  int          m_left = 0;
  bit          m_done = 0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_pend = '0;
  bit          m_ovf  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_done = 0;
      m_prod = '0;
      m_ovf  = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_done) begin
        m_prod = m_pend;
        m_ovf  = (m_pend > 32'hFFFF);
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_pend = 32'(a) * 32'(b);
        m_left = 16;
      end
    end
  end

  always @(negedge clk) begin
    check("model_busy",     32'(busy),     32'(m_left > 0));
    check("model_done",     32'(done),     32'(m_done));
    check("model_product",  product,       m_prod);
    check("model_overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a start now, optionally injects a second start mid-run, and waits for done.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        input int inj_cyc, input bit hold_chk, input logic [31:0] hold_val);
    int   cyc;
    int   busy_cnt;
    bit   seen;
    logic [31:0] exp_p;
    exp_p    = 32'(op_a) * 32'(op_b);
    busy_cnt = 0;
    seen     = 0;
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    step();
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cnt++;
      if (hold_chk) check("hold_prior_product", product, hold_val);
      if (cyc == inj_cyc) begin
        start = 1'b1;
        a     = 16'd15;
        b     = 16'd9;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("done_seen",  32'(seen),     32'd1);
    check("latency",    32'(cyc),      32'd17);
    check("busy_count", 32'(busy_cnt), 32'd16);
    check("product",    product,       exp_p);
    check("overflow",   32'(overflow), 32'(exp_p > 32'hFFFF));
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) pulses++;
      step();
    end
  endtask

  initial begin
    int          pulses;
    logic [15:0] ra;
    logic [15:0] rb;

    reset = 1'b1;
    repeat (3) step();
    check("reset_busy",     32'(busy),     32'd0);
    check("reset_done",     32'(done),     32'd0);
    check("reset_product",  product,       32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    step();

    run_op(16'd10, 16'd9, 0, 0, '0);
    check("lit_10x9", product, 32'd90);
    check("lit_10x9_ovf", 32'(overflow), 32'd0);
    step();

    run_op(16'hFFFF, 16'hFFFF, 0, 0, '0);
    check("lit_max", product, 32'hFFFE0001);
    check("lit_max_ovf", 32'(overflow), 32'd1);
    step();
    run_op(16'd0, 16'hFFFF, 0, 0, '0);
    check("lit_zero", product, 32'd0);
    check("lit_zero_ovf", 32'(overflow), 32'd0);
    step();
    run_op(16'd1, 16'hFFFF, 0, 0, '0);
    check("lit_one", product, 32'h0000FFFF);
    step();

    // Start during RUN step 5 must be ignored.
    run_op(16'd20, 16'd9, 6, 0, '0);
    check("lit_ignore_start", product, 32'd180);
    step();
    count_done(30, pulses);
    check("no_second_done", 32'(pulses), 32'd0);

    // Reset during RUN step 8 aborts with no done pulse.
    start = 1'b1;
    a     = 16'd123;
    b     = 16'd45;
    step();
    start = 1'b0;
    repeat (8) step();
    check("mid_run_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy",    32'(busy), 32'd0);
    check("abort_done",    32'(done), 32'd0);
    check("abort_product", product,   32'd0);
    count_done(25, pulses);
    check("abort_no_done", 32'(pulses), 32'd0);

    // Back-to-back: start held in DONE re-enters RUN immediately.
    run_op(16'd10, 16'd9, 0, 0, '0);
    run_op(16'd3, 16'd7, 0, 1, 32'd90);
    check("lit_b2b", product, 32'd21);
    step();

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(7))
        0:       ra = 16'd0;
        1:       ra = 16'hFFFF;
        2:       ra = 16'd1;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(7))
        0:       rb = 16'd0;
        1:       rb = 16'hFFFF;
        2:       rb = 16'd1;
        default: rb = 16'($urandom);
      endcase
      if ($urandom_range(1) == 0) repeat ($urandom_range(3, 1)) step();
      run_op(ra, rb, 0, 0, '0);
    end
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shumezuesi_sekuencial.md
SHUMEZUESI_SEKUENCIAL -- requirements
Module: shumezuesi_sekuencial

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  input  1  request to begin a multiply; sampled on clk.
REQ-004 SHALL have ports: a  input  16  multiplicand (unsigned).
REQ-005 SHALL have ports: b  input  16  multiplier (unsigned).
REQ-006 SHALL have ports: busy  output  1  high while an operation is in progress.
REQ-007 SHALL have ports: done  output  1  one-cycle pulse when product becomes valid.
REQ-008 SHALL have ports: product  output  32  last completed unsigned product a*b.
REQ-009 SHALL have ports: overflow  output  1  high when product[31:16] != 0, valid alongside product.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; a and b are captured on that edge; state -> RUN, step counter = 0, acc_hi = 0, acc_lo = b, mcand = a.
REQ-012 SHALL ignore start while in RUN; a and b changes during RUN have no effect.
REQ-013 SHALL, in each RUN cycle, form {cout, sum} = acc_hi + (acc_lo[0] ? mcand : 0) via one 16-bit adder with carry-in 0, then load {acc_hi, acc_lo} = {cout, sum, acc_lo[15:1]}.
REQ-014 SHALL execute exactly 16 RUN cycles (counter 0..15, 5-bit or 4-bit with terminal detect); counter wraps to 0 only on a new acceptance.
REQ-015 SHALL, on the edge ending RUN step 15, load product = final {acc_hi, acc_lo}, update overflow, and enter DONE.
REQ-016 SHALL assert done for exactly the one cycle spent in DONE; latency start-accept edge to done high = 17 cycles.
REQ-017 SHALL leave DONE to IDLE on the next edge unless start is high, in which case it re-enters RUN (back-to-back, no idle bubble).
REQ-018 SHALL drive busy = 1 exactly in RUN; busy = 0 in IDLE and DONE.
REQ-019 SHALL hold product and overflow stable from DONE until the next DONE; not updated by acceptance or RUN.
REQ-020 SHALL give correct results for operand 0, 1 and 0xFFFF; max product 0xFFFE0001 without loss of carry.

Reset
REQ-021 SHALL, with reset high at a clk edge, enter IDLE and clear counter, acc_hi, acc_lo, mcand, product (0x00000000), overflow, busy and done to 0.
REQ-022 SHALL give reset priority over start in the same cycle; reset mid-RUN aborts, no done pulse, product reads 0.

Structure
REQ-023 SHALL place WIDTH = 16, STEPS = 16 and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) in a shared package used by the CPU control blocks.
REQ-024 SHALL instantiate the team's existing 16-bit ripple adder Mbledhesi16bit exactly once as its only arithmetic sub-module; no '*' operator and no second adder.
REQ-025 SHALL keep FSM, counter and shift registers in this module; unused state encoding 2'd3 SHALL return to IDLE.

Verification
REQ-026 SHALL check: a=10, b=9, start 1 cycle -> busy 16 cycles, done at cycle 17, product=90, overflow=0.
REQ-027 SHALL check: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, overflow=1; a=0, b=0xFFFF -> product=0, overflow=0.
REQ-028 SHALL check: a=20, b=9 accepted, then start with a=15, b=9 at RUN step 5 -> ignored, done gives 180, no second done.
REQ-029 SHALL check: reset asserted at RUN step 8 -> next cycle IDLE, busy=0, product=0, no done pulse.
REQ-030 SHALL check: start held high in DONE with a=3, b=7 -> immediate RUN, prior product held until new done, then product=21.
REQ-031 SHALL check with a scoreboard over 1000 random (a, b) pairs: product equals a*b and overflow equals (a*b > 0xFFFF).
